// File: rtl/gb_cpu_common_pkg.sv
// rtl/gb_cpu_common_pkg.sv - shared CPU types: IDU step opcodes and burst FSM states
package gb_cpu_common_pkg;

    typedef enum logic [1:0] {
        IDU_NOP = 2'd0,
        IDU_INC = 2'd1,
        IDU_DEC = 2'd2
    } idu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } idu_burst_state_t;

endpackage

// File: rtl/gb_cpu_idu_step.sv
// rtl/gb_cpu_idu_step.sv - combinational +1/-1/hold step with modulo wrap detect
module gb_cpu_idu_step
    import gb_cpu_common_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  idu_op_t          opcode_i,
    input  logic [WIDTH-1:0] value_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o
);

    always_comb begin
        next_o = value_i;
        wrap_o = 1'b0;
        case (opcode_i)
            IDU_INC: begin
                next_o = value_i + WIDTH'(1);
                wrap_o = &value_i;
            end
            IDU_DEC: begin
                next_o = value_i - WIDTH'(1);
                wrap_o = ~|value_i;
            end
            default: begin
                next_o = value_i;
                wrap_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/gb_cpu_idu_burst.sv
// rtl/gb_cpu_idu_burst.sv - sequential IDU emitting a stepped address burst over valid/ready
module gb_cpu_idu_burst
    import gb_cpu_common_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  idu_op_t            opcode_i,
    input  logic [WIDTH-1:0]   base_i,
    input  logic [COUNT_W-1:0] count_i,
    output logic [WIDTH-1:0]   addr_o,
    output logic               addr_valid_o,
    input  logic               addr_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               wrap_o
);

    idu_burst_state_t   state_q, state_d;
    idu_op_t            opcode_q, opcode_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic               wrap_q, wrap_d;

    logic [WIDTH-1:0]   step_next;
    logic               step_wrap;

    gb_cpu_idu_step #(.WIDTH(WIDTH)) u_step (
        .opcode_i (opcode_q),
        .value_i  (addr_q),
        .next_o   (step_next),
        .wrap_o   (step_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            opcode_q    <= IDU_NOP;
            addr_q      <= '0;
            remaining_q <= '0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wrap_q      <= wrap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wrap_d      = wrap_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    opcode_d    = opcode_i;
                    addr_d      = base_i;
                    remaining_d = count_i;
                    wrap_d      = 1'b0;
                    state_d     = (count_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // The step is applied on every handshake, including the last, so
                // addr_o ends at base +/- count for register writeback.
                if (addr_ready_i) begin
                    addr_d      = step_next;
                    remaining_d = remaining_q - COUNT_W'(1);
                    wrap_d      = wrap_q | step_wrap;
                    if (remaining_q == COUNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign addr_o       = addr_q;
    assign addr_valid_o = (state_q == RUN);
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign wrap_o       = wrap_q;

endmodule

// File: tb/tb_gb_cpu_idu_burst.sv
// tb/tb_gb_cpu_idu_burst.sv - randomized self-checking bench for gb_cpu_idu_burst
module tb_gb_cpu_idu_burst;
    import gb_cpu_common_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    idu_op_t     opcode_i = IDU_NOP;
    logic [15:0] base_i = '0;
    logic [7:0]  count_i = '0;
    logic [15:0] addr_o;
    logic        addr_valid_o;
    logic        addr_ready_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        wrap_o;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gb_cpu_idu_burst #(.WIDTH(16), .COUNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .opcode_i     (opcode_i),
        .base_i       (base_i),
        .count_i      (count_i),
        .addr_o       (addr_o),
        .addr_valid_o (addr_valid_o),
        .addr_ready_i (addr_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .wrap_o       (wrap_o)
    );

    function automatic int op_delta(input idu_op_t op);
        return (op == IDU_INC) ? 1 : (op == IDU_DEC) ? -1 : 0;
    endfunction

    // Called at a negedge; returns at the negedge of the first IDLE cycle after the burst.
    task automatic run_burst(input idu_op_t op, input logic [15:0] base, input logic [7:0] cnt,
                             input int mode, input bit inject, input string tag);
        int          delta, fin, hs, stalls, cyc, a;
        bit          exp_wrap, seen_done, rdy;
        logic [15:0] exp_addr, fin_addr;
        delta    = op_delta(op);
        fin      = int'(base) + int'(cnt) * delta;
        exp_wrap = (fin < 0) || (fin > 65535);
        fin_addr = fin[15:0];
        start_i = 1'b1; opcode_i = op; base_i = base; count_i = cnt; addr_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0; base_i = 16'($urandom); count_i = 8'($urandom);
        opcode_i = idu_op_t'($urandom_range(0, 2));
        hs = 0; stalls = 0; cyc = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 600) begin
            if (cyc > 0) @(negedge clk);
            start_i = inject && (cyc == 2);
            if (start_i) begin
                base_i = base ^ 16'h5A5A; count_i = 8'd200; opcode_i = IDU_DEC;
            end
            if (hs < int'(cnt)) begin
                a = int'(base) + hs * delta;
                exp_addr = a[15:0];
                total++;
                if (addr_valid_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b1) begin
                    fails++;
                    $display("FAIL %s run_flags cyc=%0d: valid=%b done=%b busy=%b expected 1 0 1", tag, cyc, addr_valid_o, done_o, busy_o);
                end
                total++;
                if (addr_o !== exp_addr) begin
                    fails++;
                    $display("FAIL %s addr[%0d] cyc=%0d: got %h expected %h", tag, hs, cyc, addr_o, exp_addr);
                end
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    default: rdy = !(cyc == 1 || cyc == 2);
                endcase
                addr_ready_i = rdy;
                if (rdy) hs++;
                else stalls++;
            end else begin
                seen_done = 1'b1;
                addr_ready_i = 1'($urandom);
                total++;
                if (done_o !== 1'b1 || addr_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                    fails++;
                    $display("FAIL %s done_flags cyc=%0d: done=%b valid=%b busy=%b expected 1 0 1", tag, cyc, done_o, addr_valid_o, busy_o);
                end
                total++;
                if (cyc !== int'(cnt) + stalls) begin
                    fails++;
                    $display("FAIL %s done_cycle: got %0d expected %0d", tag, cyc, int'(cnt) + stalls);
                end
                total++;
                if (addr_o !== fin_addr || wrap_o !== exp_wrap) begin
                    fails++;
                    $display("FAIL %s final: addr=%h wrap=%b expected addr=%h wrap=%b", tag, addr_o, wrap_o, fin_addr, exp_wrap);
                end
            end
            cyc++;
        end
        if (!seen_done) begin
            total++; fails++;
            $display("FAIL %s timeout: no done_o after %0d cycles", tag, cyc);
        end
        @(negedge clk);
        start_i = 1'b0;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || addr_valid_o !== 1'b0 || addr_o !== fin_addr || wrap_o !== exp_wrap) begin
            fails++;
            $display("FAIL %s idle_after: busy=%b done=%b valid=%b addr=%h wrap=%b expected 0 0 0 %h %b",
                     tag, busy_o, done_o, addr_valid_o, addr_o, wrap_o, fin_addr, exp_wrap);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_i = 1'b1; opcode_i = IDU_INC; base_i = 16'($urandom); count_i = 8'd9; addr_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (addr_o !== 16'h0 || addr_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || wrap_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: addr=%h valid=%b busy=%b done=%b wrap=%b expected all 0",
                     addr_o, addr_valid_o, busy_o, done_o, wrap_o);
        end
        start_i = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (addr_o !== 16'h0 || addr_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
                fails++;
                $display("FAIL reset_quiet[%0d]: addr=%h valid=%b busy=%b done=%b expected all 0",
                         i, addr_o, addr_valid_o, busy_o, done_o);
            end
        end
    endtask

    task automatic test_directed();
        run_burst(IDU_INC, 16'hFE00, 8'd4, 0, 1'b0, "inc_burst");
        run_burst(IDU_DEC, 16'h0001, 8'd3, 0, 1'b0, "dec_wrap");
        run_burst(IDU_INC, 16'h1000, 8'd3, 2, 1'b0, "backpressure");
        run_burst(IDU_INC, 16'h4321, 8'd0, 0, 1'b0, "zero_count");
        run_burst(IDU_INC, 16'h2000, 8'd6, 0, 1'b1, "ignored_start");
        run_burst(IDU_NOP, 16'hFFFF, 8'd5, 1, 1'b0, "nop_hold");
        run_burst(IDU_INC, 16'hFFFE, 8'd2, 0, 1'b0, "inc_wrap_last_step");
    endtask

    task automatic test_back_to_back();
        run_burst(IDU_INC, 16'hC000, 8'd160, 0, 1'b0, "oam_dma");
        run_burst(IDU_DEC, 16'h00FF, 8'd255, 0, 1'b0, "max_count");
    endtask

    task automatic test_random();
        idu_op_t     op;
        logic [15:0] b;
        for (int i = 0; i < 12; i++) begin
            op = idu_op_t'($urandom_range(0, 2));
            b  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 6)) - 16'd3 : 16'($urandom);
            run_burst(op, b, 8'($urandom_range(0, 12)), 1, 1'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] b;
        b = 16'($urandom);
        start_i = 1'b1; opcode_i = IDU_INC; base_i = b; count_i = 8'd5; addr_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (addr_o !== b + 16'd2 || addr_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL midburst_progress: addr=%h valid=%b expected %h 1", addr_o, addr_valid_o, b + 16'd2);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (addr_o !== 16'h0 || addr_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || wrap_o !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: addr=%h valid=%b busy=%b done=%b wrap=%b expected all 0",
                     addr_o, addr_valid_o, busy_o, done_o, wrap_o);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (done_o !== 1'b0 || addr_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_quiet[%0d]: done=%b valid=%b busy=%b expected 0 0 0",
                         i, done_o, addr_valid_o, busy_o);
            end
        end
        run_burst(IDU_INC, 16'h8000, 8'd5, 1, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
